aes_encipher_ctrl: RTL and testbench
====================================

Name: aes_encipher_ctrl

Overview:
Sequencing stage for AES encryption. It holds the 128-bit cipher state and fetches round keys from the key memory by round index. Each cycle it drives the current state and a round type into the combinational encipher round datapath, then registers that datapath's result. It sits between the core top-level (block/next/ready/result) and the round datapath plus key memory, running one round per cycle for AES-128 and AES-256.

Parameters:
NR128, 10, round count for 128-bit keys
NR256, 14, round count for 256-bit keys

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
next  in  1  start encipher of block; accepted only when ready=1
keylen  in  1  0 = AES-128, 1 = AES-256; sampled with next
block  in  128  plaintext; byte 0 = [127:120]
ready  out  1  idle, able to accept next
result  out  128  ciphertext; held until next accepted
result_valid  out  1  result holds a completed ciphertext
round  out  4  round-key index to key memory; key memory returns key combinationally
round_key  in  128  key for current round index
rnd_type  out  2  to round datapath: 0 INIT, 1 MAIN, 2 FINAL, 3 idle (datapath outputs zeros)
rnd_key  out  128  round_key passed through to datapath
rnd_state  out  128  current state register to datapath
rnd_new_state  in  128  datapath result for current rnd_type

Behaviour:
- One clock, synchronous, active-high reset on clk. Reset values: ready=1, result_valid=0, result=0, state reg=0, round=0, rnd_type=3, FSM=IDLE, latched keylen=0.
- FSM states: IDLE, INIT, MAIN, FINAL.
- IDLE: rnd_type=3 and round=0. On next=1, on that edge: state reg <= block; nr_reg <= keylen ? NR256 : NR128; round_ctr <= 0; result_valid <= 0; go to INIT. ready drops after the edge.
- INIT: rnd_type=0 and round=0. Edge: state <= rnd_new_state; round_ctr <= 1; go to MAIN.
- MAIN: rnd_type=1 and round=round_ctr. Edge: state <= rnd_new_state; round_ctr++. Go to FINAL when round_ctr+1 == nr_reg.
- FINAL: rnd_type=2 and round=nr_reg. Edge: state <= rnd_new_state; result <= rnd_new_state; result_valid <= 1; ready <= 1; go to IDLE.
- Latency: with next sampled at edge E, ready and result_valid are high after edge E+nr+1. That gives 11 busy cycles for AES-128 and 15 for AES-256.
- next while ready=0 is ignored, including during FINAL.
- next and keylen changes mid-operation have no effect; keylen is latched at start.
- result is stable between completion and the next accepted next. result_valid clears on the edge that accepts next.
- Back-to-back: next asserted in the first cycle ready=1 after a completion starts a new block immediately.
- Reset mid-operation returns to IDLE next edge with all reset values; no partial result is exposed.
- round_ctr is 4 bits and never exceeds 14; keylen values other than 0/1 are not possible (1-bit port).

Optional Feature:
AES_ENC_ABORT_EN
- Defined: adds input abort (1 bit). abort=1 in INIT/MAIN/FINAL returns the FSM to IDLE on the next edge with ready=1 and result_valid=0. result keeps its previous value; the state reg is zeroed. abort in IDLE has no effect and has priority over nothing else (next and abort together in IDLE: next wins).
- Undefined: port absent; runs always complete.

Decomposition:
- Shared package aes_pkg holds:
  - round-type constants AES_INIT_ROUND=0, AES_MAIN_ROUND=1, AES_FINAL_ROUND=2, AES_IDLE_ROUND=3
  - AES128_NR=10, AES256_NR=14, keylen encodings
  - FSM state encoding
- No sub-module is natural. The FSM, round counter and state register form one block; the round datapath and key memory are instantiated beside it in the core top level.

Test Plan:
- FIPS-197 C.1: key 000102…0f, block 00112233445566778899aabbccddeeff, keylen=0, with golden round model and key memory -> result 69c4e0d86a7b0430d8cdb78070b4c55a. ready low exactly 11 cycles; round sequence 0..10; rnd_type sequence 0, 1×9, 2.
- FIPS-197 C.3: key 000102…1f, same block, keylen=1 -> result 8ea2b7ca516745bfeafc49904b496089 after 15 busy cycles; round reaches 14.
- next pulsed every cycle while busy, with keylen toggled -> exactly one operation; result is unchanged from the first-latched keylen run.
- Reset asserted at the 5th busy cycle -> next cycle ready=1, result_valid=0, result=0, rnd_type=3; a subsequent C.1 run is still correct.
- Back-to-back: two C.1 runs with next asserted on the first ready cycle -> result_valid low for exactly 11 cycles between them, second result correct.
- With AES_ENC_ABORT_EN, abort at round 4 -> ready=1 next cycle, result_valid=0, result keeps prior ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES encipher control path:
//   - round-type codes driven to the combinational round datapath
//   - round counts for AES-128 / AES-256 and the keylen encoding
//   - encoding of the sequencing FSM
//------------------------------------------------------------------------------
package aes_pkg;

   // Round type presented to the encipher round datapath
   localparam logic [1:0] AES_INIT_ROUND  = 2'd0;
   localparam logic [1:0] AES_MAIN_ROUND  = 2'd1;
   localparam logic [1:0] AES_FINAL_ROUND = 2'd2;
   localparam logic [1:0] AES_IDLE_ROUND  = 2'd3;

   // Number of rounds per key length
   localparam int AES128_NR = 10;
   localparam int AES256_NR = 14;

   // keylen input encoding
   localparam logic AES_KEYLEN_128 = 1'b0;
   localparam logic AES_KEYLEN_256 = 1'b1;

   // Sequencing FSM
   typedef enum logic [1:0] {
      CTRL_IDLE  = 2'd0,
      CTRL_INIT  = 2'd1,
      CTRL_MAIN  = 2'd2,
      CTRL_FINAL = 2'd3
   } ctrl_state_t;

endpackage : aes_pkg

// File: rtl/aes_encipher_ctrl.sv
//------------------------------------------------------------------------------
// aes_encipher_ctrl
// Sequencing stage for AES encryption. Holds the 128-bit cipher state, steps a
// round index into the key memory and drives one round per cycle through the
// external combinational round datapath (INIT, MAIN x (nr-1), FINAL).
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   next            start a block (accepted only while ready=1)
//   keylen          0 = AES-128, 1 = AES-256, latched with next
//   block           plaintext, byte 0 in [127:120]
//   ready           idle, able to accept next
//   result          last ciphertext, held until next is accepted
//   result_valid    result holds a completed ciphertext
//   round           round-key index to key memory
//   round_key       round key returned by key memory for 'round'
//   rnd_type        round type to datapath (0 INIT,1 MAIN,2 FINAL,3 idle)
//   rnd_key         round_key passed through to datapath
//   rnd_state       current state register to datapath
//   rnd_new_state   datapath result for the current rnd_type
//   abort           (only with AES_ENC_ABORT_EN) cancel a running block
//
// Build option:
//   AES_ENC_ABORT_EN  adds the abort input; without it every run completes.
//------------------------------------------------------------------------------
import aes_pkg::*;

module aes_encipher_ctrl #(
   parameter int NR128 = AES128_NR,
   parameter int NR256 = AES256_NR
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         next,
   input  logic         keylen,
   input  logic [127:0] block,
   output logic         ready,
   output logic [127:0] result,
   output logic         result_valid,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   output logic [1:0]   rnd_type,
   output logic [127:0] rnd_key,
   output logic [127:0] rnd_state,
`ifdef AES_ENC_ABORT_EN
   input  logic         abort,
`endif
   input  logic [127:0] rnd_new_state
);

   ctrl_state_t  r_fsm;
   ctrl_state_t  w_fsm_next;
   logic [127:0] r_state;
   logic [127:0] r_result;
   logic         r_result_valid;
   logic [3:0]   r_round_ctr;
   logic         r_keylen;
   logic [3:0]   w_nr;
   logic [1:0]   w_rnd_type;
   logic [3:0]   w_round;
   logic         w_accept;
   logic         w_abort;

   // Round count follows the key length latched at start of the block
   assign w_nr = (r_keylen == AES_KEYLEN_256) ? 4'(NR256) : 4'(NR128);

`ifdef AES_ENC_ABORT_EN
   // abort only matters while busy; in IDLE a simultaneous next wins
   assign w_abort = abort && (r_fsm != CTRL_IDLE);
`else
   assign w_abort = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // Next-state and datapath control
   //---------------------------------------------------------------------------
   always_comb begin
      w_fsm_next = r_fsm;
      w_rnd_type = AES_IDLE_ROUND;
      w_round    = 4'd0;
      w_accept   = 1'b0;

      case (r_fsm)
         CTRL_IDLE: begin
            if (next) begin
               w_accept   = 1'b1;
               w_fsm_next = CTRL_INIT;
            end
         end
         CTRL_INIT: begin
            w_rnd_type = AES_INIT_ROUND;
            w_fsm_next = CTRL_MAIN;
         end
         CTRL_MAIN: begin
            w_rnd_type = AES_MAIN_ROUND;
            w_round    = r_round_ctr;
            // Last MAIN round is nr-1; FINAL uses key index nr
            if (r_round_ctr + 4'd1 == w_nr) begin
               w_fsm_next = CTRL_FINAL;
            end
         end
         CTRL_FINAL: begin
            w_rnd_type = AES_FINAL_ROUND;
            w_round    = w_nr;
            w_fsm_next = CTRL_IDLE;
         end
         default: begin
            w_fsm_next = CTRL_IDLE;
         end
      endcase

      if (w_abort) begin
         w_fsm_next = CTRL_IDLE;
      end
   end

   //---------------------------------------------------------------------------
   // State register, round counter, result capture
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fsm          <= CTRL_IDLE;
         r_state        <= '0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_round_ctr    <= 4'd0;
         r_keylen       <= AES_KEYLEN_128;
      end else begin
         r_fsm <= w_fsm_next;
         if (w_abort) begin
            // Cancelled run: drop the partial state, keep the old ciphertext
            r_state        <= '0;
            r_result_valid <= 1'b0;
            r_round_ctr    <= 4'd0;
         end else begin
            case (r_fsm)
               CTRL_IDLE: begin
                  if (w_accept) begin
                     r_state        <= block;
                     r_keylen       <= keylen;
                     r_round_ctr    <= 4'd0;
                     r_result_valid <= 1'b0;
                  end
               end
               CTRL_INIT: begin
                  r_state     <= rnd_new_state;
                  r_round_ctr <= 4'd1;
               end
               CTRL_MAIN: begin
                  r_state     <= rnd_new_state;
                  r_round_ctr <= r_round_ctr + 4'd1;
               end
               CTRL_FINAL: begin
                  r_state        <= rnd_new_state;
                  r_result       <= rnd_new_state;
                  r_result_valid <= 1'b1;
               end
               default: begin
                  r_state <= r_state;
               end
            endcase
         end
      end
   end

   assign ready        = (r_fsm == CTRL_IDLE);
   assign result       = r_result;
   assign result_valid = r_result_valid;
   assign round        = w_round;
   assign rnd_type     = w_rnd_type;
   assign rnd_key      = round_key;
   assign rnd_state    = r_state;

endmodule : aes_encipher_ctrl

// File: tb/tb_aes_encipher_ctrl.sv
//------------------------------------------------------------------------------
// tb_aes_encipher_ctrl
// Bench for aes_encipher_ctrl. Surrounds the controller with a behavioural AES
// round datapath and key memory, and compares against a whole-block AES
// reference function plus FIPS-197 C.1 / C.3 ciphertexts.
//------------------------------------------------------------------------------
module tb_aes_encipher_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         next;
   logic         keylen;
   logic [127:0] block;
   logic         ready;
   logic [127:0] result;
   logic         result_valid;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [1:0]   rnd_type;
   logic [127:0] rnd_key;
   logic [127:0] rnd_state;
   logic [127:0] rnd_new_state;
`ifdef AES_ENC_ABORT_EN
   logic         abort;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [127:0] kmem [0:15];

   always #5 clk = ~clk;

   aes_encipher_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .next          (next),
      .keylen        (keylen),
      .block         (block),
      .ready         (ready),
      .result        (result),
      .result_valid  (result_valid),
      .round         (round),
      .round_key     (round_key),
      .rnd_type      (rnd_type),
      .rnd_key       (rnd_key),
      .rnd_state     (rnd_state),
`ifdef AES_ENC_ABORT_EN
      .abort         (abort),
`endif
      .rnd_new_state (rnd_new_state)
   );

   // ---------------- AES building blocks ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d = {v, v};
      logic [15:0] s = d >> (8 - n);
      return s[7:0];
   endfunction

   // S-box from its definition: GF(2^8) inverse (x^254) then affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r = 8'h01;
      logic [7:0] p = x;
      logic [7:0] e = 8'd254;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gmul(r, p);
         p = gmul(p, p);
      end
      if (x == 8'h00) r = 8'h00;
      return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-8*(4*c)   -: 8];
         a1 = s[127-8*(4*c+1) -: 8];
         a2 = s[127-8*(4*c+2) -: 8];
         a3 = s[127-8*(4*c+3) -: 8];
         o[127-8*(4*c)   -: 8] = gmul(a0,8'd2) ^ gmul(a1,8'd3) ^ a2 ^ a3;
         o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1,8'd2) ^ gmul(a2,8'd3) ^ a3;
         o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2,8'd2) ^ gmul(a3,8'd3);
         o[127-8*(4*c+3) -: 8] = gmul(a0,8'd3) ^ a1 ^ a2 ^ gmul(a3,8'd2);
      end
      return o;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Round key r of the expanded schedule; AES-128 keys live in key[255:128]
   function automatic logic [127:0] rkey(input logic [255:0] key, input logic kl, input int r);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      int nk = kl ? 8 : 4;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(r+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = xtime(rc);
         end else if (nk == 8 && i % nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // Whole-block reference cipher
   function automatic logic [127:0] aes_ref(input logic [127:0] blk, input logic [255:0] key,
                                            input logic kl);
      int nr = kl ? 14 : 10;
      logic [127:0] s = blk ^ rkey(key, kl, 0);
      for (int r = 1; r < nr; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rkey(key, kl, r);
      return shift_rows(sub_bytes(s)) ^ rkey(key, kl, nr);
   endfunction

   // ---------------- surrounding datapath and key memory ----------------
   always_comb begin
      rnd_new_state = '0;
      case (rnd_type)
         2'd0:    rnd_new_state = rnd_state ^ rnd_key;
         2'd1:    rnd_new_state = mix_columns(shift_rows(sub_bytes(rnd_state))) ^ rnd_key;
         2'd2:    rnd_new_state = shift_rows(sub_bytes(rnd_state)) ^ rnd_key;
         default: rnd_new_state = '0;
      endcase
   end

   assign round_key = kmem[round];

   // ---------------- bench helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_keys(input logic [255:0] key, input logic kl);
      for (int r = 0; r < 15; r++) kmem[r] = rkey(key, kl, r);
      kmem[15] = '0;
   endtask

   // Start one block in the current (ready) cycle and follow it to completion.
   // hammer: keep next high and toggle keylen every busy cycle.
   task automatic run_op(input logic [127:0] blk, input logic [255:0] key, input logic kl,
                         input bit hammer, input string tag);
      int nr = kl ? 14 : 10;
      int cnt = 0;
      int bad_round = 0, bad_type = 0, bad_key = 0, bad_valid = 0;
      logic [1:0] exp_type;
      load_keys(key, kl);
      block  = blk;
      keylen = kl;
      next   = 1'b1;
      tick();
      if (!hammer) next = 1'b0;
      while (ready !== 1'b1 && cnt < 40) begin
         exp_type = (cnt == 0) ? 2'd0 : ((cnt == nr) ? 2'd2 : 2'd1);
         if (round !== 4'(cnt))               bad_round++;
         if (rnd_type !== exp_type)           bad_type++;
         if (rnd_key !== rkey(key, kl, cnt))  bad_key++;
         if (result_valid !== 1'b0)           bad_valid++;
         if (cnt == 0 && rnd_state !== blk)   bad_type++;
         if (hammer) keylen = ~keylen;
         cnt++;
         tick();
      end
      next = 1'b0;
      chk({tag, "_busy_cycles"}, 128'(cnt), 128'(nr + 1));
      chk({tag, "_round_seq"},   128'(bad_round), 128'd0);
      chk({tag, "_type_seq"},    128'(bad_type), 128'd0);
      chk({tag, "_key_seq"},     128'(bad_key), 128'd0);
      chk({tag, "_valid_low"},   128'(bad_valid), 128'd0);
      chk({tag, "_ready"},       128'(ready), 128'd1);
      chk({tag, "_valid"},       128'(result_valid), 128'd1);
      chk({tag, "_result"},      result, aes_ref(blk, key, kl));
   endtask

   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] held;
      logic [127:0] rb;
      logic [255:0] rk;
      logic         rkl;
      int           k;

      reset  = 1'b1;
      next   = 1'b0;
      keylen = 1'b0;
      block  = '0;
`ifdef AES_ENC_ABORT_EN
      abort  = 1'b0;
`endif
      load_keys(K128, 1'b0);
      tick();
      tick();
      chk("rst_ready",     128'(ready), 128'd1);
      chk("rst_valid",     128'(result_valid), 128'd0);
      chk("rst_result",    result, 128'd0);
      chk("rst_rnd_type",  128'(rnd_type), 128'd3);
      chk("rst_round",     128'(round), 128'd0);
      chk("rst_state",     rnd_state, 128'd0);
      reset = 1'b0;
      tick();

      // FIPS-197 C.1 and C.3
      run_op(PT, K128, 1'b0, 1'b0, "c1");
      chk("c1_golden", result, CT1);
      held = result;
      repeat (3) tick();
      chk("hold_result", result, held);
      chk("hold_valid",  128'(result_valid), 128'd1);

      run_op(PT, K256, 1'b1, 1'b0, "c3");
      chk("c3_golden", result, CT3);

      // next held high and keylen toggled while busy: one AES-128 run only
      run_op(PT, K128, 1'b0, 1'b1, "hammer");
      chk("hammer_golden", result, CT1);
      tick();
      chk("hammer_no_restart", 128'(ready), 128'd1);

      // Reset in the 5th busy cycle
      load_keys(K128, 1'b0);
      block = PT; keylen = 1'b0; next = 1'b1;
      tick();
      next = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_ready",    128'(ready), 128'd1);
      chk("midrst_valid",    128'(result_valid), 128'd0);
      chk("midrst_result",   result, 128'd0);
      chk("midrst_rnd_type", 128'(rnd_type), 128'd3);
      run_op(PT, K128, 1'b0, 1'b0, "after_rst");
      chk("after_rst_golden", result, CT1);

      // Back-to-back: next in the first ready cycle
      run_op(PT, K128, 1'b0, 1'b0, "b2b_a");
      run_op(PT, K128, 1'b0, 1'b0, "b2b_b");
      chk("b2b_golden", result, CT1);

      // Randomized blocks, keys and key lengths
      for (int i = 0; i < 4; i++) begin
         rb  = {$urandom, $urandom, $urandom, $urandom};
         rk  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         rkl = 1'($urandom_range(0, 1));
         tick();
         run_op(rb, rk, rkl, 1'b0, "rand");
      end

`ifdef AES_ENC_ABORT_EN
      run_op(PT, K128, 1'b0, 1'b0, "pre_abort");
      held = result;
      load_keys(K256, 1'b1);
      block = PT; keylen = 1'b1; next = 1'b1;
      tick();
      next = 1'b0;
      k = 0;
      while (round !== 4'd4 && k < 20) begin
         k++;
         tick();
      end
      chk("abort_reached_r4", 128'(round), 128'd4);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_ready",  128'(ready), 128'd1);
      chk("abort_valid",  128'(result_valid), 128'd0);
      chk("abort_result", result, held);
      chk("abort_state",  rnd_state, 128'd0);
      run_op(PT, K256, 1'b1, 1'b0, "post_abort");
`endif

      k = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_aes_encipher_ctrl
